mc_ctrl: RTL and testbench

- Multi-cycle main control FSM for the simple CPU datapath.
- Decodes the instruction-register opcode/funct and sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK.
- Drives the 3-bit ALU operation code and all datapath enables; consumes the ALU zero flag to resolve beq.
- Supported instructions: add, sub, ori, lw, sw, beq.

---
 rtl/mc_ctrl.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_mc_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle main control FSM for the simple CPU datapath.
// Sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK for add, sub, ori, lw,
// sw and beq. Decodes opcode/funct from the IR and drives the ALU
// operation code and all datapath enables. Outputs are decoded
// combinationally from the current state (plus opcode/funct). While rst
// is high, every write enable is held low, so a reset raised
// mid-instruction cancels the pending write within the same cycle.
module mc_ctrl #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_ORI   = 6'b001101,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] FN_ADD   = 6'b100000,
    parameter logic [5:0] FN_SUB   = 6'b100010
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic [2:0] alu_ctrl,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       ext_zero,
    output logic       pc_wr,
    output logic       pc_src,
    output logic       ir_wr,
    output logic       dm_wr,
    output logic       rf_wr,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       illegal,
    output logic [2:0] state
);

    // State encoding is visible on the debug port, so the values are fixed.
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXE    = 3'd2,
        MEM_RD = 3'd3,
        MEM_WR = 3'd4,
        WB_ALU = 3'd5,
        WB_MEM = 3'd6,
        BRANCH = 3'd7
    } state_t;

    // ALU operation codes.
    localparam logic [2:0] ALU_NONE = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_ORI  = 3'b010;
    localparam logic [2:0] ALU_SUB  = 3'b011;
    localparam logic [2:0] ALU_BEQ  = 3'b101;
    localparam logic [2:0] ALU_LW   = 3'b110;
    localparam logic [2:0] ALU_SW   = 3'b111;

    // ALU operand B selects.
    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BOFS = 2'b11;

    state_t     state_r;
    state_t     next_state_s;

    logic [2:0] alu_ctrl_s;
    logic       alu_src_a_s;
    logic [1:0] alu_src_b_s;
    logic       ext_zero_s;
    logic       pc_wr_s;
    logic       pc_src_s;
    logic       ir_wr_s;
    logic       dm_wr_s;
    logic       rf_wr_s;
    logic       reg_dst_s;
    logic       mem_to_reg_s;
    logic       illegal_s;
    logic       legal_s;

    // Only add and sub are implemented among the R-type functions.
    function automatic logic rtype_funct_ok(input logic [5:0] fn);
        logic ok;
        ok = 1'b0;
        if ((fn == FN_ADD) || (fn == FN_SUB)) begin
            ok = 1'b1;
        end else begin
            ok = 1'b0;
        end
        return ok;
    endfunction

    // An instruction is legal when its opcode is supported and, for
    // R-type, its funct is one of the implemented functions.
    function automatic logic instr_legal(input logic [5:0] op, input logic [5:0] fn);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_RTYPE: ok = rtype_funct_ok(fn);
            OP_ORI:   ok = 1'b1;
            OP_LW:    ok = 1'b1;
            OP_SW:    ok = 1'b1;
            OP_BEQ:   ok = 1'b1;
            default:  ok = 1'b0;
        endcase
        return ok;
    endfunction

    assign legal_s = instr_legal(opcode, funct);
    assign state   = state_r;

    // State register; an asynchronous reset returns the FSM to FETCH at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode; illegal instructions fall straight back to FETCH.
    always_comb begin
        next_state_s = FETCH;
        case (state_r)
            FETCH: begin
                next_state_s = DECODE;
            end
            DECODE: begin
                if (!legal_s) begin
                    next_state_s = FETCH;
                end else if (opcode == OP_BEQ) begin
                    next_state_s = BRANCH;
                end else begin
                    next_state_s = EXE;
                end
            end
            EXE: begin
                case (opcode)
                    OP_LW:    next_state_s = MEM_RD;
                    OP_SW:    next_state_s = MEM_WR;
                    OP_RTYPE: next_state_s = WB_ALU;
                    OP_ORI:   next_state_s = WB_ALU;
                    default:  next_state_s = FETCH;
                endcase
            end
            MEM_RD: begin
                next_state_s = WB_MEM;
            end
            MEM_WR: begin
                next_state_s = FETCH;
            end
            WB_ALU: begin
                next_state_s = FETCH;
            end
            WB_MEM: begin
                next_state_s = FETCH;
            end
            BRANCH: begin
                next_state_s = FETCH;
            end
            default: begin
                next_state_s = FETCH;
            end
        endcase
    end

    // Per-state datapath controls; anything a state does not drive stays 0.
    always_comb begin
        alu_ctrl_s   = ALU_NONE;
        alu_src_a_s  = 1'b0;
        alu_src_b_s  = SRCB_REG;
        ext_zero_s   = 1'b0;
        pc_wr_s      = 1'b0;
        pc_src_s     = 1'b0;
        ir_wr_s      = 1'b0;
        dm_wr_s      = 1'b0;
        rf_wr_s      = 1'b0;
        reg_dst_s    = 1'b0;
        mem_to_reg_s = 1'b0;
        illegal_s    = 1'b0;
        case (state_r)
            FETCH: begin
                // IR <- mem[PC], PC <- PC + 4
                ir_wr_s     = 1'b1;
                pc_wr_s     = 1'b1;
                pc_src_s    = 1'b0;
                alu_src_a_s = 1'b0;
                alu_src_b_s = SRCB_FOUR;
                alu_ctrl_s  = ALU_ADD;
            end
            DECODE: begin
                // Precompute the branch target into ALUOut.
                alu_src_a_s = 1'b0;
                alu_src_b_s = SRCB_BOFS;
                alu_ctrl_s  = ALU_ADD;
                illegal_s   = ~legal_s;
            end
            EXE: begin
                alu_src_a_s = 1'b1;
                case (opcode)
                    OP_RTYPE: begin
                        alu_src_b_s = SRCB_REG;
                        alu_ctrl_s  = (funct == FN_SUB) ? ALU_SUB : ALU_ADD;
                    end
                    OP_ORI: begin
                        alu_src_b_s = SRCB_IMM;
                        ext_zero_s  = 1'b1;
                        alu_ctrl_s  = ALU_ORI;
                    end
                    OP_LW: begin
                        alu_src_b_s = SRCB_IMM;
                        alu_ctrl_s  = ALU_LW;
                    end
                    OP_SW: begin
                        alu_src_b_s = SRCB_IMM;
                        alu_ctrl_s  = ALU_SW;
                    end
                    default: begin
                        alu_src_b_s = SRCB_REG;
                        alu_ctrl_s  = ALU_NONE;
                    end
                endcase
            end
            MEM_RD: begin
                // The memory read into MDR needs no enable.
                alu_ctrl_s = ALU_NONE;
            end
            MEM_WR: begin
                dm_wr_s = 1'b1;
            end
            WB_ALU: begin
                rf_wr_s      = 1'b1;
                mem_to_reg_s = 1'b0;
                reg_dst_s    = (opcode == OP_RTYPE) ? 1'b1 : 1'b0;
            end
            WB_MEM: begin
                rf_wr_s      = 1'b1;
                mem_to_reg_s = 1'b1;
                reg_dst_s    = 1'b0;
            end
            BRANCH: begin
                // Compare A and B; the taken target comes from ALUOut.
                alu_src_a_s = 1'b1;
                alu_src_b_s = SRCB_REG;
                alu_ctrl_s  = ALU_BEQ;
                pc_src_s    = 1'b1;
                pc_wr_s     = zero;
            end
            default: begin
                alu_ctrl_s = ALU_NONE;
            end
        endcase
    end

    // While reset is high, mask every enable so no write can slip through.
    always_comb begin
        alu_src_a  = alu_src_a_s;
        alu_src_b  = alu_src_b_s;
        ext_zero   = ext_zero_s;
        pc_src     = pc_src_s;
        reg_dst    = reg_dst_s;
        mem_to_reg = mem_to_reg_s;
        if (rst) begin
            alu_ctrl = ALU_ADD;
            pc_wr    = 1'b0;
            ir_wr    = 1'b0;
            dm_wr    = 1'b0;
            rf_wr    = 1'b0;
            illegal  = 1'b0;
        end else begin
            alu_ctrl = alu_ctrl_s;
            pc_wr    = pc_wr_s;
            ir_wr    = ir_wr_s;
            dm_wr    = dm_wr_s;
            rf_wr    = rf_wr_s;
            illegal  = illegal_s;
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: table-driven directed test for mc_ctrl, with a hand-written
// sequence for an asynchronous reset that lands in MEM_WR.
module tb_mc_ctrl;

    logic       clk;
    logic       rst;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic [2:0] alu_ctrl;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_zero;
    logic       pc_wr;
    logic       pc_src;
    logic       ir_wr;
    logic       dm_wr;
    logic       rf_wr;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       illegal;
    logic [2:0] state;

    int total;
    int bad;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic [17:0] exp;
    } vec_t;

    vec_t vecs[$];

    mc_ctrl dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .alu_ctrl(alu_ctrl), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .ext_zero(ext_zero), .pc_wr(pc_wr), .pc_src(pc_src), .ir_wr(ir_wr),
        .dm_wr(dm_wr), .rf_wr(rf_wr), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .illegal(illegal), .state(state)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Packs expected outputs; flags = {pc_wr,pc_src,ir_wr,dm_wr,rf_wr,reg_dst,mem_to_reg,illegal}.
    function automatic logic [17:0] e(input logic [2:0] st, input logic [2:0] alu,
                                      input logic sa, input logic [1:0] sb,
                                      input logic ez, input logic [7:0] flags);
        return {st, alu, sa, sb, ez, flags};
    endfunction

    function automatic logic [17:0] got_vec();
        return {state, alu_ctrl, alu_src_a, alu_src_b, ext_zero,
                pc_wr, pc_src, ir_wr, dm_wr, rf_wr, reg_dst, mem_to_reg, illegal};
    endfunction

    task automatic add_vec(input logic r, input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input logic [17:0] ex);
        vec_t v;
        v.rst = r; v.op = op; v.fn = fn; v.z = z; v.exp = ex;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [17:0] got, input logic [17:0] ex);
        total++;
        if (got !== ex) begin
            bad++;
            $display("FAIL %s: got=%b expected=%b", name, got, ex);
        end
    endtask

    task automatic chk1(input string name, input logic got, input logic ex);
        total++;
        if (got !== ex) begin
            bad++;
            $display("FAIL %s: got=%b expected=%b", name, got, ex);
        end
    endtask

    initial begin
        logic [17:0] fe;
        logic [17:0] de;
        logic [17:0] di;
        total  = 0;
        bad    = 0;
        rst    = 1'b1;
        opcode = 6'h00;
        funct  = 6'h20;
        zero   = 1'b0;

        fe = e(3'd0, 3'b001, 1'b0, 2'b01, 1'b0, 8'b1010_0000);
        de = e(3'd1, 3'b001, 1'b0, 2'b11, 1'b0, 8'b0000_0000);
        di = e(3'd1, 3'b001, 1'b0, 2'b11, 1'b0, 8'b0000_0001);

        // reset held: FETCH with enables masked, then release
        add_vec(1'b1, 6'h00, 6'h20, 1'b0, e(3'd0, 3'b001, 1'b0, 2'b01, 1'b0, 8'h00));
        // add: 0,1,2,5
        add_vec(1'b0, 6'h00, 6'h20, 1'b0, fe);
        add_vec(1'b0, 6'h00, 6'h20, 1'b0, de);
        add_vec(1'b0, 6'h00, 6'h20, 1'b0, e(3'd2, 3'b001, 1'b1, 2'b00, 1'b0, 8'h00));
        add_vec(1'b0, 6'h00, 6'h20, 1'b0, e(3'd5, 3'b000, 1'b0, 2'b00, 1'b0, 8'b0000_1100));
        // sub
        add_vec(1'b0, 6'h00, 6'h22, 1'b0, fe);
        add_vec(1'b0, 6'h00, 6'h22, 1'b0, de);
        add_vec(1'b0, 6'h00, 6'h22, 1'b0, e(3'd2, 3'b011, 1'b1, 2'b00, 1'b0, 8'h00));
        add_vec(1'b0, 6'h00, 6'h22, 1'b0, e(3'd5, 3'b000, 1'b0, 2'b00, 1'b0, 8'b0000_1100));
        // lw: 0,1,2,3,6
        add_vec(1'b0, 6'h23, 6'h00, 1'b0, fe);
        add_vec(1'b0, 6'h23, 6'h00, 1'b0, de);
        add_vec(1'b0, 6'h23, 6'h00, 1'b0, e(3'd2, 3'b110, 1'b1, 2'b10, 1'b0, 8'h00));
        add_vec(1'b0, 6'h23, 6'h00, 1'b0, e(3'd3, 3'b000, 1'b0, 2'b00, 1'b0, 8'h00));
        add_vec(1'b0, 6'h23, 6'h00, 1'b0, e(3'd6, 3'b000, 1'b0, 2'b00, 1'b0, 8'b0000_1010));
        // sw: 0,1,2,4
        add_vec(1'b0, 6'h2B, 6'h00, 1'b0, fe);
        add_vec(1'b0, 6'h2B, 6'h00, 1'b0, de);
        add_vec(1'b0, 6'h2B, 6'h00, 1'b0, e(3'd2, 3'b111, 1'b1, 2'b10, 1'b0, 8'h00));
        add_vec(1'b0, 6'h2B, 6'h00, 1'b0, e(3'd4, 3'b000, 1'b0, 2'b00, 1'b0, 8'b0001_0000));
        // ori (garbage opcode during FETCH is ignored)
        add_vec(1'b0, 6'h3F, 6'h00, 1'b0, fe);
        add_vec(1'b0, 6'h0D, 6'h00, 1'b0, de);
        add_vec(1'b0, 6'h0D, 6'h00, 1'b0, e(3'd2, 3'b010, 1'b1, 2'b10, 1'b1, 8'h00));
        add_vec(1'b0, 6'h0D, 6'h00, 1'b0, e(3'd5, 3'b000, 1'b0, 2'b00, 1'b0, 8'b0000_1000));
        // beq taken (zero high in DECODE must not write PC)
        add_vec(1'b0, 6'h04, 6'h00, 1'b1, fe);
        add_vec(1'b0, 6'h04, 6'h00, 1'b1, de);
        add_vec(1'b0, 6'h04, 6'h00, 1'b1, e(3'd7, 3'b101, 1'b1, 2'b00, 1'b0, 8'b1100_0000));
        // beq not taken
        add_vec(1'b0, 6'h04, 6'h00, 1'b0, fe);
        add_vec(1'b0, 6'h04, 6'h00, 1'b0, de);
        add_vec(1'b0, 6'h04, 6'h00, 1'b0, e(3'd7, 3'b101, 1'b1, 2'b00, 1'b0, 8'b0100_0000));
        // illegal opcode
        add_vec(1'b0, 6'h3F, 6'h00, 1'b0, fe);
        add_vec(1'b0, 6'h3F, 6'h00, 1'b0, di);
        // illegal R-type funct
        add_vec(1'b0, 6'h00, 6'h24, 1'b0, fe);
        add_vec(1'b0, 6'h00, 6'h24, 1'b0, di);
        // back in FETCH after the illegal one
        add_vec(1'b0, 6'h00, 6'h20, 1'b0, fe);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst    = vecs[i].rst;
            opcode = vecs[i].op;
            funct  = vecs[i].fn;
            zero   = vecs[i].z;
            #1;
            chk($sformatf("vec%0d", i), got_vec(), vecs[i].exp);
        end

        // async reset in the middle of MEM_WR
        @(negedge clk);
        rst = 1'b1; opcode = 6'h2B; funct = 6'h00; zero = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("sw_fetch", got_vec(), fe);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("sw_memwr", got_vec(), e(3'd4, 3'b000, 1'b0, 2'b00, 1'b0, 8'b0001_0000));
        #1;
        rst = 1'b1;
        #1;
        chk1("rst_dm_wr_drop", dm_wr, 1'b0);
        chk("rst_state", got_vec(), e(3'd0, 3'b001, 1'b0, 2'b01, 1'b0, 8'h00));
        @(negedge clk);
        #1;
        chk1("rst_hold_ir_wr", ir_wr, 1'b0);
        rst = 1'b0;
        #1;
        chk("rel_fetch", got_vec(), fe);
        @(negedge clk);
        #1;
        chk("rel_decode", got_vec(), de);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
